// File: rtl/wb_io_timer.sv
// Wishbone I/O responder: scratch register plus a prescaled interrupt timer.
// Define IO_TIMER_EN to build the timer; otherwise only SCRATCH and the handshake exist.
module wb_io_timer #(
  parameter logic [15:0] BASE        = 16'h00b0,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned PRESCALE    = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [15:0] adr_i,
  input  logic [15:0] dat_i,
  output logic [15:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  input  logic        byte_i,
  output logic        ack_o,
  output logic        irq_o
);

  if (BASE[2:0] != 3'b000) begin : g_bad_base
    $error("BASE must be 8-byte aligned");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end

  localparam logic [2:0] WS_LAST =
    3'(WAIT_STATES == 0 ? 0 : WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  wcnt_q, wcnt_d;
  logic        hit, go_ack, wr;
  logic [1:0]  sel;
  logic [15:0] scratch_q, word_rd, rdat, dat_q;
  logic [15:0] reload_rd, count_rd, ctrl_rd;

  // Merge write data into the old value according to the byte lane.
  function automatic logic [15:0] merge(
    input logic [15:0] old,
    input logic [15:0] d,
    input logic        b,
    input logic        a0
  );
    if (!b) return d;
    if (a0) return {d[7:0], old[7:0]};
    return {old[15:8], d[7:0]};
  endfunction

  assign hit = stb_i && (adr_i[15:3] == BASE[15:3]);
  assign sel = adr_i[2:1];
  assign wr  = go_ack && we_i;

  // Handshake state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next state; go_ack marks the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    go_ack  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          wcnt_d = '0;
          if (WAIT_STATES == 0) begin
            state_d = ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (wcnt_q == WS_LAST) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux, byte reads return the addressed byte in the low lane.
  always_comb begin
    word_rd = scratch_q;
    unique case (sel)
      2'd0:    word_rd = scratch_q;
      2'd1:    word_rd = reload_rd;
      2'd2:    word_rd = count_rd;
      default: word_rd = ctrl_rd;
    endcase
    rdat = word_rd;
    if (byte_i) begin
      rdat = {8'h00, adr_i[0] ? word_rd[15:8] : word_rd[7:0]};
    end
  end

  // Scratch register and read-data capture on the edge entering ACK.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scratch_q <= '0;
      dat_q     <= '0;
    end else begin
      if (wr && sel == 2'd0) begin
        scratch_q <= merge(scratch_q, dat_i, byte_i, adr_i[0]);
      end
      dat_q <= go_ack ? rdat : 16'h0000;
    end
  end

  assign ack_o = (state_q == ACK);
  assign dat_o = dat_q;

`ifdef IO_TIMER_EN
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [15:0] reload_q, count_q, pre_q, rel_new, ctl_new;
  logic        en_q, ar_q, ie_q, exp_q;
  logic        tick, expire, wr_rel, wr_ctl, ctl_lo, w1c;

  assign tick    = en_q && (pre_q == PS_LAST);
  assign expire  = tick && (count_q == 16'h0000);
  assign wr_rel  = wr && sel == 2'd1;
  assign wr_ctl  = wr && sel == 2'd3;
  assign ctl_lo  = wr_ctl && (!byte_i || !adr_i[0]);
  assign w1c     = wr_ctl && (byte_i ? (adr_i[0] && dat_i[0]) : dat_i[8]);
  assign rel_new = merge(reload_q, dat_i, byte_i, adr_i[0]);
  assign ctl_new = merge(ctrl_rd, dat_i, byte_i, adr_i[0]);

  assign reload_rd = reload_q;
  assign count_rd  = count_q;
  assign ctrl_rd   = {7'b0, exp_q, 5'b0, ie_q, ar_q, en_q};
  assign irq_o     = exp_q && ie_q;

  // Prescaler, down-counter and control; register writes beat timer events,
  // except that an expiry beats a same-cycle clear of the expired flag.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      reload_q <= '0;
      count_q  <= '0;
      pre_q    <= '0;
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      ie_q     <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      if (wr_rel || !en_q || tick) pre_q <= '0;
      else                         pre_q <= pre_q + 16'd1;

      if (wr_rel)      reload_q <= rel_new;

      if (wr_rel)      count_q <= rel_new;
      else if (expire) count_q <= ar_q ? reload_q : 16'h0000;
      else if (tick)   count_q <= count_q - 16'd1;

      if (expire)      exp_q <= 1'b1;
      else if (w1c)    exp_q <= 1'b0;

      if (ctl_lo) begin
        en_q <= ctl_new[0];
        ar_q <= ctl_new[1];
        ie_q <= ctl_new[2];
      end else if (expire) begin
        en_q <= ar_q;
      end
    end
  end
`else
  assign reload_rd = 16'h0000;
  assign count_rd  = 16'h0000;
  assign ctrl_rd   = 16'h0000;
  assign irq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_io_timer.sv
// Bench for wb_io_timer: two instances (0 and 3 wait states),
// vector table plus timer and abort sequences.
module tb_wb_io_timer;

  localparam logic [15:0] BASE = 16'h00b0;
`ifdef IO_TIMER_EN
  localparam bit TMR = 1'b1;
`else
  localparam bit TMR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] adr, wdat, dat0, dat3;
  logic        we, bsel, stb0, stb3;
  logic        ack0, ack3, irq0, irq3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_commit = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wb_io_timer #(
    .BASE(BASE), .WAIT_STATES(0), .PRESCALE(4)
  ) u0 (
    .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat0), .we_i(we),
    .stb_i(stb0), .byte_i(bsel), .ack_o(ack0),
    .irq_o(irq0)
  );

  wb_io_timer #(
    .BASE(BASE), .WAIT_STATES(3), .PRESCALE(16)
  ) u3 (
    .clk_i(clk), .rst_n_i(rst_n), .adr_i(adr),
    .dat_i(wdat), .dat_o(dat3), .we_i(we),
    .stb_i(stb3), .byte_i(bsel), .ack_o(ack3),
    .irq_o(irq3)
  );

  typedef struct {
    logic        w;
    logic        b;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] e;
  } vec_t;

  vec_t vt[19];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One bus transfer; read expectations go through the scoreboard queue.
  task automatic bus(input bit d3, input bit w, input bit b,
                     input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] e);
    int n;
    logic ackv;
    logic [15:0] got;
    @(negedge clk);
    adr = a; wdat = d; we = w; bsel = b;
    if (!w) exp_q.push_back(e);
    if (d3) stb3 = 1'b1; else stb0 = 1'b1;
    n = 0;
    ackv = 1'b0;
    while (!ackv && n < 40) begin
      @(posedge clk); #1;
      n++;
      ackv = d3 ? ack3 : ack0;
    end
    got = d3 ? dat3 : dat0;
    stb0 = 1'b0; stb3 = 1'b0;
    last_commit = cyc;
    chk(d3 ? "latency_ws3" : "latency_ws0", n, d3 ? 4 : 1);
    if (!w) begin
      if (exp_q.size() > 0) chk("read_data", got, exp_q.pop_front());
      else chk("scoreboard_empty", 1, 0);
    end
    @(posedge clk); #1;
    chk("ack_one_cycle", d3 ? ack3 : ack0, 1'b0);
  endtask

  task automatic wait_irq(input string name, input int target);
    int k;
    k = 0;
    while (!irq0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(name, cyc, target);
  endtask

  initial begin
    int c0, c1, acks;
    logic seen;
    rst_n = 1'b0; adr = '0; wdat = '0;
    we = 1'b0; bsel = 1'b0; stb0 = 1'b0; stb3 = 1'b0;

    vt[0]  = '{1'b0, 1'b0, BASE + 16'd0, 16'h0, 16'h0000};
    vt[1]  = '{1'b0, 1'b0, BASE + 16'd2, 16'h0, 16'h0000};
    vt[2]  = '{1'b0, 1'b0, BASE + 16'd4, 16'h0, 16'h0000};
    vt[3]  = '{1'b0, 1'b0, BASE + 16'd6, 16'h0, 16'h0000};
    vt[4]  = '{1'b1, 1'b0, BASE + 16'd0, 16'h1234, 16'h0};
    vt[5]  = '{1'b0, 1'b0, BASE + 16'd0, 16'h0, 16'h1234};
    vt[6]  = '{1'b1, 1'b1, BASE + 16'd1, 16'h00ab, 16'h0};
    vt[7]  = '{1'b0, 1'b0, BASE + 16'd0, 16'h0, 16'hab34};
    vt[8]  = '{1'b0, 1'b1, BASE + 16'd1, 16'h0, 16'h00ab};
    vt[9]  = '{1'b0, 1'b1, BASE + 16'd0, 16'h0, 16'h0034};
    vt[10] = '{1'b1, 1'b0, BASE + 16'd1, 16'h5678, 16'h0};
    vt[11] = '{1'b0, 1'b0, BASE + 16'd0, 16'h0, 16'h5678};
    vt[12] = '{1'b1, 1'b0, BASE + 16'd6, 16'h0006, 16'h0};
    vt[13] = '{1'b0, 1'b0, BASE + 16'd6, 16'h0, TMR ? 16'h0006 : 16'h0};
    vt[14] = '{1'b1, 1'b0, BASE + 16'd2, 16'h0009, 16'h0};
    vt[15] = '{1'b0, 1'b0, BASE + 16'd4, 16'h0, TMR ? 16'h0009 : 16'h0};
    vt[16] = '{1'b0, 1'b1, BASE + 16'd3, 16'h0, 16'h0000};
    vt[17] = '{1'b1, 1'b0, BASE + 16'd6, 16'h0000, 16'h0};
    vt[18] = '{1'b0, 1'b0, BASE + 16'd2, 16'h0, TMR ? 16'h0009 : 16'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack0", ack0, 1'b0);
    chk("reset_ack3", ack3, 1'b0);
    chk("reset_irq0", irq0, 1'b0);
    chk("reset_irq3", irq3, 1'b0);
    chk("reset_dat0", dat0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 19; i++) begin
        bus(d[0], vt[i].w, vt[i].b, vt[i].a, vt[i].d, vt[i].e);
      end
    end

`ifndef IO_TIMER_EN
    bus(1'b0, 1'b1, 1'b0, BASE + 16'd6, 16'h0007, 16'h0);
    bus(1'b0, 1'b0, 1'b0, BASE + 16'd6, 16'h0, 16'h0000);
`endif

    @(negedge clk);
    adr = BASE + 16'd8; we = 1'b0; bsel = 1'b0; stb0 = 1'b1;
    acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack0) acks++;
    end
    stb0 = 1'b0;
    chk("outside_window_ack", acks, 0);

`ifdef IO_TIMER_EN
    bus(1'b0, 1'b1, 1'b0, BASE + 16'd2, 16'h0003, 16'h0);
    bus(1'b0, 1'b1, 1'b0, BASE + 16'd6, 16'h0007, 16'h0);
    c0 = last_commit;
    wait_irq("irq_first_period", c0 + 16);
    bus(1'b0, 1'b0, 1'b0, BASE + 16'd6, 16'h0, 16'h0107);
    bus(1'b0, 1'b1, 1'b1, BASE + 16'd7, 16'h0001, 16'h0);
    chk("irq_cleared_w1c", irq0, 1'b0);
    wait_irq("irq_second_period", c0 + 32);
    bus(1'b0, 1'b1, 1'b1, BASE + 16'd7, 16'h0001, 16'h0);
    chk("irq_cleared_again", irq0, 1'b0);
    while (cyc < c0 + 47) begin
      @(posedge clk); #1;
    end
    bus(1'b0, 1'b1, 1'b1, BASE + 16'd7, 16'h0001, 16'h0);
    chk("w1c_on_expiry_cycle", last_commit, c0 + 48);
    chk("irq_set_wins", irq0, 1'b1);
    bus(1'b0, 1'b1, 1'b0, BASE + 16'd6, 16'h0100, 16'h0);
    chk("irq_falls_ctrl0100", irq0, 1'b0);
    bus(1'b0, 1'b0, 1'b0, BASE + 16'd6, 16'h0, 16'h0000);

    bus(1'b0, 1'b1, 1'b0, BASE + 16'd2, 16'h0002, 16'h0);
    bus(1'b0, 1'b1, 1'b0, BASE + 16'd6, 16'h0001, 16'h0);
    c1 = last_commit;
    repeat (30) @(posedge clk);
    #1;
    chk("oneshot_irq_masked", irq0, 1'b0);
    bus(1'b0, 1'b0, 1'b0, BASE + 16'd6, 16'h0, 16'h0100);
    bus(1'b0, 1'b0, 1'b0, BASE + 16'd4, 16'h0, 16'h0000);
    repeat (20) @(posedge clk);
    bus(1'b0, 1'b0, 1'b0, BASE + 16'd4, 16'h0, 16'h0000);
    chk("oneshot_started", c1 > c0, 1'b1);
`endif

    bus(1'b1, 1'b1, 1'b0, BASE, 16'h1234, 16'h0);
    @(negedge clk);
    adr = BASE; wdat = 16'h5555; we = 1'b1; bsel = 1'b0; stb3 = 1'b1;
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= ack3;
    end
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen |= ack3;
    end
    stb3 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= ack3;
    end
    chk("abort_no_ack", seen, 1'b0);
    bus(1'b1, 1'b0, 1'b0, BASE, 16'h0, 16'h0000);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
